parking_lot_ctrl: RTL

// Parametrised parking-lot controller; next generation of the fixed 4-slot FSM.

---
 rtl/parking_pkg.sv | 27 ++
 rtl/parking_slot_timer.sv | 27 ++
 rtl/parking_lot_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot controller.
package parking_pkg;

    // Gate actuator states
    typedef enum logic {
        G_CLOSED = 1'b0,
        G_OPEN   = 1'b1
    } gate_state_t;

    localparam int DEFAULT_TICK_DIV  = 40_000_000;
    localparam int DEFAULT_GATE_HOLD = 40_000_000;
    localparam int DEFAULT_FULL_HOLD = 40_000_000;

    // Bits needed to hold values 0..value-1, never less than 1
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/parking_slot_timer.sv
// Per-slot parked-seconds counter: saturating, cleared on demand,
// forced to zero while the slot is free.
module parking_slot_timer #(
    parameter int TIME_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              tick,
    input  logic              enable,
    output logic [TIME_W-1:0] count
);

    localparam logic [TIME_W-1:0] TIME_MAX = '1;

    // Clear has priority over a coincident tick so a fresh car starts at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (tick && (count != TIME_MAX)) begin
            count <= count + TIME_W'(1);
        end
    end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parametrised parking-lot controller: lowest-free-slot allocation,
// exit validation, per-slot parked time, timed gate and lot-full indications.
//
// Handshake: entry_req/exit_req are single-cycle request pulses with no
// back-pressure. Every request is answered exactly one cycle later by a
// single-cycle pulse on entry_ack, exit_ack or exit_err (a rejected entry
// produces no ack and raises full_flag instead); assigned_slot and
// parked_time are valid in the ack cycle and hold afterwards.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = $clog2(NUM_SLOTS),
    parameter int TICK_DIV  = DEFAULT_TICK_DIV,
    parameter int GATE_HOLD = DEFAULT_GATE_HOLD,
    parameter int FULL_HOLD = DEFAULT_FULL_HOLD,
    parameter int TIME_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic [NUM_SLOTS-1:0] spots,
    output logic [SLOT_W:0]      free_count,
    output logic [SLOT_W-1:0]    next_free,
    output logic                 entry_ack,
    output logic [SLOT_W-1:0]    assigned_slot,
    output logic                 exit_ack,
    output logic                 exit_err,
    output logic [TIME_W-1:0]    parked_time,
    output logic                 gate_open,
    output logic                 full_flag,
    output gate_state_t          gate_state
);

    localparam int TICK_CW = clog2(TICK_DIV);
    localparam int GATE_CW = clog2(GATE_HOLD);
    localparam int FULL_CW = clog2(FULL_HOLD);

    localparam logic [TICK_CW-1:0] TICK_LAST  = TICK_CW'(TICK_DIV - 1);
    localparam logic [GATE_CW-1:0] GATE_LAST  = GATE_CW'(GATE_HOLD - 1);
    localparam logic [FULL_CW-1:0] FULL_LAST  = FULL_CW'(FULL_HOLD - 1);
    localparam logic [SLOT_W:0]    SLOT_COUNT = (SLOT_W + 1)'(NUM_SLOTS);

    logic [TICK_CW-1:0]   tick_cnt;
    logic                 tick;
    logic [GATE_CW-1:0]   gate_cnt;
    logic [FULL_CW-1:0]   full_cnt;
    logic                 slot_valid;
    logic                 entry_ok;
    logic                 exit_ok;
    logic                 gate_trig;
    logic [NUM_SLOTS-1:0] set_mask;
    logic [NUM_SLOTS-1:0] clr_mask;
    logic [TIME_W-1:0]    slot_time [NUM_SLOTS];

    assign tick       = (tick_cnt == TICK_LAST);
    assign slot_valid = ({1'b0, exit_slot} < SLOT_COUNT);
    assign entry_ok   = entry_req && (free_count != '0);
    assign exit_ok    = exit_req && slot_valid && spots[exit_slot];
    assign gate_trig  = entry_ok || exit_ok;

    // Shared one-second prescaler for all slot timers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_CW'(1);
        end
    end

    // Lowest free slot wins; downward scan so the last hit is the lowest index
    always_comb begin
        next_free = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!spots[i]) begin
                next_free = SLOT_W'(i);
            end
        end
    end

    // Occupancy bits touched this cycle (entry slot is always free, exit slot occupied)
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (entry_ok) begin
            set_mask[next_free] = 1'b1;
        end
        if (exit_ok) begin
            clr_mask[exit_slot] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        parking_slot_timer #(
            .TIME_W (TIME_W)
        ) u_timer (
            .clk    (clk),
            .rst    (reset),
            .clear  (set_mask[g] | clr_mask[g]),
            .tick   (tick),
            .enable (spots[g]),
            .count  (slot_time[g])
        );
    end

    // Occupancy, free count and request responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spots         <= '0;
            free_count    <= SLOT_COUNT;
            entry_ack     <= 1'b0;
            assigned_slot <= '0;
            exit_ack      <= 1'b0;
            exit_err      <= 1'b0;
            parked_time   <= '0;
        end else begin
            entry_ack <= entry_ok;
            exit_ack  <= exit_ok;
            exit_err  <= exit_req && !exit_ok;
            spots     <= (spots | set_mask) & ~clr_mask;
            if (entry_ok) begin
                assigned_slot <= next_free;
            end
            if (exit_ok) begin
                parked_time <= slot_time[exit_slot];
            end
            case ({entry_ok, exit_ok})
                2'b10:   free_count <= free_count - (SLOT_W + 1)'(1);
                2'b01:   free_count <= free_count + (SLOT_W + 1)'(1);
                default: free_count <= free_count;
            endcase
        end
    end

    // Gate FSM: any accepted car (re)starts the hold period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_state <= G_CLOSED;
            gate_cnt   <= '0;
            gate_open  <= 1'b0;
        end else begin
            case (gate_state)
                G_CLOSED: begin
                    if (gate_trig) begin
                        gate_state <= G_OPEN;
                        gate_cnt   <= GATE_LAST;
                        gate_open  <= 1'b1;
                    end
                end
                G_OPEN: begin
                    if (gate_trig) begin
                        gate_cnt <= GATE_LAST;
                    end else if (gate_cnt == '0) begin
                        gate_state <= G_CLOSED;
                        gate_open  <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt - GATE_CW'(1);
                    end
                end
                default: begin
                    gate_state <= G_CLOSED;
                    gate_open  <= 1'b0;
                end
            endcase
        end
    end

    // Lot-full indication: an accepted exit clears it even alongside a rejected entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_flag <= 1'b0;
            full_cnt  <= '0;
        end else if (exit_ok) begin
            full_flag <= 1'b0;
            full_cnt  <= '0;
        end else if (entry_req && !entry_ok) begin
            full_flag <= 1'b1;
            full_cnt  <= FULL_LAST;
        end else if (full_flag) begin
            if (full_cnt == '0) begin
                full_flag <= 1'b0;
            end else begin
                full_cnt <= full_cnt - FULL_CW'(1);
            end
        end
    end

endmodule
